// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the FPU datapath: field widths, encodings,
// rounding-mode codes and the special-operand classification carried down the pipe.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MAN_W  = FRAC_W + 1;
    localparam int PROD_W = 2 * MAN_W;
    localparam int BIAS   = 127;

    localparam logic [EXP_W-1:0] EXP_MAX    = 8'hff;
    localparam logic [31:0]      QNAN       = 32'h7fc00000;
    localparam logic [30:0]      MAX_FINITE = 31'h7f7fffff;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RD  = 2'b01;
    localparam logic [1:0] RM_RU  = 2'b10;
    localparam logic [1:0] RM_RZ  = 2'b11;

    typedef enum logic [1:0] {
        SPC_NONE,
        SPC_ZERO,
        SPC_INF,
        SPC_NAN
    } special_e;

    // Leading-zero count of the raw product; an all-zero input returns 47.
    function automatic logic [5:0] lzc48(input logic [PROD_W-1:0] v);
        logic [5:0] n;
        n = 6'd47;
        for (int i = 0; i < PROD_W; i++) begin
            if (v[i]) begin
                n = 6'(PROD_W - 1 - i);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fp32_mul_round_pack.sv
// Final multiplier stage: normalizes the 48-bit significand product, denormalizes
// tiny results, rounds in the requested mode and packs the binary32 result.
module fp32_mul_round_pack
    import fp32_pkg::*;
(
    input  logic              i_sign,
    input  logic [10:0]       i_expSum,
    input  logic [PROD_W-1:0] i_prod,
    input  logic [1:0]        i_rm,
    input  logic [1:0]        i_special,
    output logic [31:0]       o_result
);

    logic [5:0]         w_lz;
    logic [PROD_W-1:0]  w_norm;
    logic signed [10:0] w_exp;
    logic signed [10:0] w_shAmt;
    logic [5:0]         w_shClamp;
    logic [PROD_W-1:0]  w_shifted;
    logic               w_lost;
    logic               w_guard;
    logic               w_sticky;
    logic               w_inexact;
    logic               w_inc;
    logic [EXP_W-1:0]   w_expField;
    logic               w_preOvf;
    logic [30:0]        w_base;
    logic [30:0]        w_rounded;
    logic               w_overflow;
    logic [31:0]        w_ovfValue;

    // w_exp is the biased exponent once the leading one sits at bit 47.
    assign w_lz   = lzc48(i_prod);
    assign w_norm = i_prod << w_lz;
    assign w_exp  = $signed(i_expSum) - $signed({5'b0, w_lz});

    // Tiny results shift right until the exponent reaches 1; anything past 48 is all sticky.
    assign w_shAmt = 11'sd1 - w_exp;

    always_comb begin
        w_shClamp = 6'd0;
        if (w_exp < 11'sd1) begin
            if (w_shAmt > 11'sd48) begin
                w_shClamp = 6'd48;
            end else begin
                w_shClamp = w_shAmt[5:0];
            end
        end
    end

    assign w_shifted = w_norm >> w_shClamp;
    assign w_lost    = |(w_norm & ~({PROD_W{1'b1}} << w_shClamp));
    assign w_guard   = w_shifted[23];
    assign w_sticky  = (|w_shifted[22:0]) | w_lost;
    assign w_inexact = w_guard | w_sticky;

    // The hidden bit survives only for normal results, so it selects the exponent field.
    assign w_expField = w_shifted[47] ? w_exp[EXP_W-1:0] : {EXP_W{1'b0}};
    assign w_preOvf   = w_shifted[47] && (w_exp > 11'sd254);

    always_comb begin
        w_inc = 1'b0;
        case (i_rm)
            RM_RNE:  w_inc = w_guard & (w_sticky | w_shifted[24]);
            RM_RD:   w_inc = i_sign & w_inexact;
            RM_RU:   w_inc = ~i_sign & w_inexact;
            default: w_inc = 1'b0;
        endcase
    end

    // Rounding on the packed {exp,frac} lets a mantissa carry bump the exponent for free.
    assign w_base     = {w_expField, w_shifted[46:24]};
    assign w_rounded  = w_base + {30'd0, w_inc};
    assign w_overflow = w_preOvf || (w_rounded[30:23] == EXP_MAX);

    always_comb begin
        w_ovfValue = {i_sign, EXP_MAX, {FRAC_W{1'b0}}};
        case (i_rm)
            RM_RZ: w_ovfValue = {i_sign, MAX_FINITE};
            RM_RD: begin
                if (!i_sign) begin
                    w_ovfValue = {1'b0, MAX_FINITE};
                end
            end
            RM_RU: begin
                if (i_sign) begin
                    w_ovfValue = {1'b1, MAX_FINITE};
                end
            end
            default: w_ovfValue = {i_sign, EXP_MAX, {FRAC_W{1'b0}}};
        endcase
    end

    always_comb begin
        o_result = {i_sign, w_rounded};
        case (i_special)
            SPC_NAN:  o_result = QNAN;
            SPC_INF:  o_result = {i_sign, EXP_MAX, {FRAC_W{1'b0}}};
            SPC_ZERO: o_result = {i_sign, 31'd0};
            default: begin
                if (w_overflow) begin
                    o_result = w_ovfValue;
                end
            end
        endcase
    end

endmodule

// File: rtl/pipelined_float_multiplier.sv
// Three-stage binary32 multiplier: unpack and split partial products, finish the
// 48-bit product, then normalize/round/pack combinationally from the second register set.
module pipelined_float_multiplier
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  rm,
    input  logic        e,
    output logic [31:0] s
);

    logic             w_aExpNz;
    logic             w_bExpNz;
    logic             w_aFracNz;
    logic             w_bFracNz;
    logic             w_aExpMax;
    logic             w_bExpMax;
    logic             w_aNan;
    logic             w_bNan;
    logic             w_aInf;
    logic             w_bInf;
    logic             w_aZero;
    logic             w_bZero;
    logic [EXP_W-1:0] w_aExp;
    logic [EXP_W-1:0] w_bExp;
    logic [MAN_W-1:0] w_aMan;
    logic [MAN_W-1:0] w_bMan;
    logic [10:0]      w_expSum;
    logic [35:0]      w_ppLo;
    logic [35:0]      w_ppHi;
    logic             w_sign;
    special_e         w_special;

    logic             r_s1Sign;
    logic [10:0]      r_s1ExpSum;
    logic [1:0]       r_s1Rm;
    special_e         r_s1Special;
    logic [35:0]      r_s1PpLo;
    logic [35:0]      r_s1PpHi;

    logic              r_s2Sign;
    logic [10:0]       r_s2ExpSum;
    logic [1:0]        r_s2Rm;
    special_e          r_s2Special;
    logic [PROD_W-1:0] r_s2Prod;

    assign w_aExpNz  = |a[30:23];
    assign w_bExpNz  = |b[30:23];
    assign w_aFracNz = |a[22:0];
    assign w_bFracNz = |b[22:0];
    assign w_aExpMax = (a[30:23] == EXP_MAX);
    assign w_bExpMax = (b[30:23] == EXP_MAX);

    assign w_aNan  = w_aExpMax & w_aFracNz;
    assign w_bNan  = w_bExpMax & w_bFracNz;
    assign w_aInf  = w_aExpMax & ~w_aFracNz;
    assign w_bInf  = w_bExpMax & ~w_bFracNz;
    assign w_aZero = ~w_aExpNz & ~w_aFracNz;
    assign w_bZero = ~w_bExpNz & ~w_bFracNz;

    // Subnormals share the exponent of the smallest normal and lack the hidden bit.
    assign w_aExp = w_aExpNz ? a[30:23] : 8'd1;
    assign w_bExp = w_bExpNz ? b[30:23] : 8'd1;
    assign w_aMan = {w_aExpNz, a[22:0]};
    assign w_bMan = {w_bExpNz, b[22:0]};

    assign w_sign   = a[31] ^ b[31];
    assign w_expSum = {3'b0, w_aExp} + {3'b0, w_bExp} - 11'(BIAS - 1);

    // Product split on the B operand halves; stage 2 merges them with a 12-bit offset.
    assign w_ppLo = {12'b0, w_aMan} * {24'b0, w_bMan[11:0]};
    assign w_ppHi = {12'b0, w_aMan} * {24'b0, w_bMan[23:12]};

    always_comb begin
        w_special = SPC_NONE;
        if (w_aNan || w_bNan || (w_aInf && w_bZero) || (w_bInf && w_aZero)) begin
            w_special = SPC_NAN;
        end else if (w_aInf || w_bInf) begin
            w_special = SPC_INF;
        end else if (w_aZero || w_bZero) begin
            w_special = SPC_ZERO;
        end
    end

    // Cleared registers decode as +0, which is what s must show during reset.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_s1Sign    <= 1'b0;
            r_s1ExpSum  <= 11'd0;
            r_s1Rm      <= RM_RNE;
            r_s1Special <= SPC_ZERO;
            r_s1PpLo    <= 36'd0;
            r_s1PpHi    <= 36'd0;
        end else if (e) begin
            r_s1Sign    <= w_sign;
            r_s1ExpSum  <= w_expSum;
            r_s1Rm      <= rm;
            r_s1Special <= w_special;
            r_s1PpLo    <= w_ppLo;
            r_s1PpHi    <= w_ppHi;
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_s2Sign    <= 1'b0;
            r_s2ExpSum  <= 11'd0;
            r_s2Rm      <= RM_RNE;
            r_s2Special <= SPC_ZERO;
            r_s2Prod    <= {PROD_W{1'b0}};
        end else if (e) begin
            r_s2Sign    <= r_s1Sign;
            r_s2ExpSum  <= r_s1ExpSum;
            r_s2Rm      <= r_s1Rm;
            r_s2Special <= r_s1Special;
            r_s2Prod    <= {12'b0, r_s1PpLo} + {r_s1PpHi, 12'b0};
        end
    end

    fp32_mul_round_pack u_roundPack (
        .i_sign    (r_s2Sign),
        .i_expSum  (r_s2ExpSum),
        .i_prod    (r_s2Prod),
        .i_rm      (r_s2Rm),
        .i_special (r_s2Special),
        .o_result  (s)
    );

endmodule

// File: tb/tb_pipelined_float_multiplier.sv
// Self-checking bench for pipelined_float_multiplier: directed corner cases plus
// random operands compared against a value-level binary32 multiply model.
module tb_pipelined_float_multiplier;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic        e;
    logic [31:0] s;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          valid;
        logic [31:0] value;
        string       tag;
    } expect_t;

    expect_t expQ[$];

    pipelined_float_multiplier dut (
        .clk  (clk),
        .clrn (clrn),
        .a    (a),
        .b    (b),
        .rm   (rm),
        .e    (e),
        .s    (s)
    );

    always #5 clk = ~clk;

    // Rounds the exact product M*2^X onto the binary32 grid whose quantum is
    // 2^max(p-23,-149), p being the exponent of the product's leading one.
    function automatic logic [31:0] refMul(input logic [31:0] x, input logic [31:0] y,
                                           input logic [1:0] mode);
        bit sgn, xNan, yNan, xInf, yInf, xZero, yZero;
        bit inexact, above, tie, up;
        int ex, ey, xe, ye, bigX, p, k, d, msb;
        longint unsigned mx, my, m, q, r, half;
        sgn   = x[31] ^ y[31];
        ex    = int'(x[30:23]);
        ey    = int'(y[30:23]);
        xNan  = (ex == 255) && (x[22:0] != 0);
        yNan  = (ey == 255) && (y[22:0] != 0);
        xInf  = (ex == 255) && (x[22:0] == 0);
        yInf  = (ey == 255) && (y[22:0] == 0);
        xZero = (ex == 0) && (x[22:0] == 0);
        yZero = (ey == 0) && (y[22:0] == 0);
        if (xNan || yNan || (xInf && yZero) || (yInf && xZero)) return 32'h7fc00000;
        if (xInf || yInf) return {sgn, 8'hff, 23'h0};
        if (xZero || yZero) return {sgn, 31'h0};
        mx = 64'(x[22:0]);
        my = 64'(y[22:0]);
        if (ex != 0) mx = mx + 64'h800000;
        if (ey != 0) my = my + 64'h800000;
        xe   = (ex == 0) ? -149 : ex - 150;
        ye   = (ey == 0) ? -149 : ey - 150;
        m    = mx * my;
        bigX = xe + ye;
        msb  = 0;
        for (int i = 0; i < 64; i++) if (m[i]) msb = i;
        p = bigX + msb;
        k = (p - 23 > -149) ? p - 23 : -149;
        d = k - bigX;
        if (d <= 0) begin
            q = m << (-d);
            inexact = 0; above = 0; tie = 0;
        end else if (d >= 60) begin
            q = 0;
            inexact = 1; above = 0; tie = 0;
        end else begin
            q       = m >> d;
            r       = m - (q << d);
            half    = 64'd1 << (d - 1);
            inexact = (r != 0);
            above   = (r > half);
            tie     = (r == half);
        end
        case (mode)
            2'd0:    up = above || (tie && q[0]);
            2'd1:    up = sgn && inexact;
            2'd2:    up = !sgn && inexact;
            default: up = 0;
        endcase
        if (up) q = q + 1;
        if (q == 64'h1000000) begin
            q = 64'h800000;
            k = k + 1;
        end
        if (q < 64'h800000) return {sgn, 8'h00, q[22:0]};
        if (k + 150 >= 255) begin
            case (mode)
                2'd0:    return {sgn, 8'hff, 23'h0};
                2'd1:    return sgn ? {1'b1, 8'hff, 23'h0} : 32'h7f7fffff;
                2'd2:    return sgn ? 32'hff7fffff : {1'b0, 8'hff, 23'h0};
                default: return {sgn, 31'h7f7fffff};
            endcase
        end
        return {sgn, 8'(k + 150), q[22:0]};
    endfunction

    function automatic logic [31:0] randOperand();
        int sel;
        logic [31:0] pick;
        sel = int'($urandom_range(0, 99));
        if (sel < 6) begin
            case ($urandom_range(0, 4))
                0:       pick = 32'h00000000;
                1:       pick = 32'h7f800000;
                2:       pick = 32'h7fc00001;
                3:       pick = 32'h7f800001;
                default: pick = 32'h80000000;
            endcase
            pick[31] = 1'($urandom_range(0, 1));
        end else if (sel < 18) begin
            pick = {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};
        end else begin
            pick = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
        end
        return pick;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] expected);
        checks++;
        assert (s === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, s, expected);
        end
    endtask

    // One enabled cycle: check the result issued two cycles ago, then issue a new pair.
    task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB,
                                 input logic [1:0] mode, input logic [31:0] expected,
                                 input bit valid, input string tag);
        expect_t item;
        @(negedge clk);
        if (expQ.size() >= 2) begin
            item = expQ.pop_front();
            if (item.valid) checkOutput(item.tag, item.value);
        end
        a  = opA;
        b  = opB;
        rm = mode;
        expQ.push_back('{valid, expected, tag});
    endtask

    // After reset both register sets decode as +0; the next edge loads 0*0.
    task automatic resetQueue();
        a  = 32'h0;
        b  = 32'h0;
        rm = 2'b00;
        expQ.delete();
        expQ.push_back('{1'b1, 32'h0, "flushed_r2"});
        expQ.push_back('{1'b1, 32'h0, "flushed_r1"});
    endtask

    task automatic randomBurst(input int count, input string prefix);
        logic [31:0] ra, rb;
        logic [1:0]  rmode;
        for (int i = 0; i < count; i++) begin
            ra    = randOperand();
            rb    = randOperand();
            rmode = 2'($urandom_range(0, 3));
            applyStimulus(ra, rb, rmode, refMul(ra, rb, rmode), 1'b1,
                          $sformatf("%s%0d_%08h_%08h_rm%0d", prefix, i, ra, rb, rmode));
        end
    endtask

    task automatic holdEnable(input int cycles);
        expect_t item;
        @(negedge clk);
        item = expQ.pop_front();
        if (item.valid) checkOutput(item.tag, item.value);
        e = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (item.valid) checkOutput("hold_frozen", item.value);
        end
        e = 1'b1;
        expQ.push_back('{1'b0, 32'h0, "bubble"});
    endtask

    task automatic midReset();
        @(negedge clk);
        #2 clrn = 1'b1;
        #1 checkOutput("clrn_async", 32'h0);
        @(negedge clk);
        checkOutput("clrn_held", 32'h0);
        clrn = 1'b0;
        resetQueue();
    endtask

    initial begin
        clrn = 1'b1;
        e    = 1'b1;
        a    = 32'h0;
        b    = 32'h0;
        rm   = 2'b00;
        #1 checkOutput("reset_init", 32'h0);
        @(negedge clk);
        checkOutput("reset_hold", 32'h0);
        clrn = 1'b0;
        resetQueue();

        applyStimulus(32'h3fc00000, 32'h3fc00000, 2'b00, 32'h40100000, 1'b1, "mul_1p5_sq");
        applyStimulus(32'h00800000, 32'h00800000, 2'b00, 32'h00000000, 1'b1, "uf_minnorm_sq");
        applyStimulus(32'h00800000, 32'h3f000000, 2'b00, 32'h00400000, 1'b1, "uf_half");
        applyStimulus(32'h003fffff, 32'h40000000, 2'b00, 32'h007ffffe, 1'b1, "sub_times2");
        applyStimulus(32'h7f7fffff, 32'h7f7fffff, 2'b00, 32'h7f800000, 1'b1, "ovf_rne");
        applyStimulus(32'h7f7fffff, 32'h7f7fffff, 2'b11, 32'h7f7fffff, 1'b1, "ovf_rz");
        applyStimulus(32'h7f7fffff, 32'h7f7fffff, 2'b01, 32'h7f7fffff, 1'b1, "ovf_rd_pos");
        applyStimulus(32'hff7fffff, 32'h7f7fffff, 2'b01, 32'hff800000, 1'b1, "ovf_rd_neg");
        applyStimulus(32'hff7fffff, 32'h7f7fffff, 2'b10, 32'hff7fffff, 1'b1, "ovf_ru_neg");
        applyStimulus(32'h7f800000, 32'h00ffffff, 2'b00, 32'h7f800000, 1'b1, "inf_x_fin");
        applyStimulus(32'h7f800000, 32'h00000000, 2'b00, 32'h7fc00000, 1'b1, "inf_x_zero");
        applyStimulus(32'h7ff000ff, 32'h3f80ff00, 2'b00, 32'h7fc00000, 1'b1, "nan_in");
        applyStimulus(32'h80000000, 32'h3f800000, 2'b00, 32'h80000000, 1'b1, "negzero_x1");
        applyStimulus(32'h3f800001, 32'h3f800001, 2'b00, 32'h3f800002, 1'b1, "rnd_rne_inexact");
        applyStimulus(32'h3f800001, 32'h3f800001, 2'b10, 32'h3f800003, 1'b1, "rnd_ru_inexact");
        applyStimulus(32'h3f800001, 32'h3fc00000, 2'b00, 32'h3fc00002, 1'b1, "tie_odd_up");
        applyStimulus(32'h3f800003, 32'h3fc00000, 2'b00, 32'h3fc00004, 1'b1, "tie_even_keep");
        applyStimulus(32'h3f800001, 32'h3fc00000, 2'b11, 32'h3fc00001, 1'b1, "tie_rz");
        applyStimulus(32'h007fffff, 32'h3f800001, 2'b00, 32'h00800000, 1'b1, "sub_to_minnorm");
        applyStimulus(32'h007fffff, 32'h3f800001, 2'b11, 32'h007fffff, 1'b1, "sub_rz");

        randomBurst(150, "randA");
        holdEnable(3);
        randomBurst(60, "randB");
        midReset();
        randomBurst(120, "randC");

        applyStimulus(32'h0, 32'h0, 2'b00, 32'h0, 1'b0, "drain0");
        applyStimulus(32'h0, 32'h0, 2'b00, 32'h0, 1'b0, "drain1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
